// File: rtl/parameter_shadow_ram.sv
`default_nettype none
// ============================================================================
// Module   : parameter_shadow_ram
// Brief    : Ping-pong parameter RAM; CPU edits the shadow bank, the datapath
//            reads the active bank; commit + frame_strobe swaps, then copy-back.
// Revision : 1.0
// ============================================================================
module parameter_shadow_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W:0]       s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_read,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  input  logic                  frame_strobe,
  output logic                  active_bank,
  output logic                  busy
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COPY  = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];

  state_t            r_state;
  logic              r_active_bank;
  logic              r_overrun;
  logic [15:0]       r_swap_count;
  logic [ADDR_W:0]   r_cp_idx;      // MSB set once every word has been read
  logic              r_cp_wr;
  logic [ADDR_W-1:0] r_cp_wr_idx;
  logic [DATA_W-1:0] r_cp_data;

  logic              w_busy;
  logic              w_ctrl_space;
  logic [ADDR_W-1:0] w_ctrl_off;
  logic [ADDR_W:0]   w_shadow_addr;
  logic              w_s1_rd;
  logic              w_s1_mem_wr;
  logic              w_ctrl_wr;
  logic              w_commit;
  logic              w_clr_ovr;
  logic              w_cp_rd;
  logic              w_cp_last;
  logic [DATA_W-1:0] w_ctrl_rdata;

  assign w_busy         = (r_state != ST_IDLE);
  assign w_ctrl_space   = s1_address[ADDR_W];
  assign w_ctrl_off     = s1_address[ADDR_W-1:0];
  assign w_shadow_addr  = {~r_active_bank, s1_address[ADDR_W-1:0]};
  assign s1_waitrequest = s1_chipselect & (s1_read | s1_write) & ~w_ctrl_space & w_busy;
  assign w_s1_rd        = s1_chipselect & s1_read & ~s1_waitrequest;
  assign w_s1_mem_wr    = s1_chipselect & s1_write & ~w_ctrl_space & ~w_busy;
  assign w_ctrl_wr      = s1_chipselect & s1_write & w_ctrl_space & (w_ctrl_off == '0);
  assign w_commit       = w_ctrl_wr & s1_writedata[0];
  assign w_clr_ovr      = w_ctrl_wr & s1_writedata[1];
  // The datapath owns the active-bank read port; copy-back yields to it.
  assign w_cp_rd        = (r_state == ST_COPY) & ~s2_read & ~r_cp_idx[ADDR_W];
  assign w_cp_last      = r_cp_wr & (&r_cp_wr_idx);
  assign active_bank    = r_active_bank;
  assign busy           = w_busy;

  always_comb begin
    w_ctrl_rdata = '0;
    if (w_ctrl_off == ADDR_W'(0)) begin
      w_ctrl_rdata[2:0] = {r_overrun, w_busy, r_active_bank};
    end else if (w_ctrl_off == ADDR_W'(1)) begin
      w_ctrl_rdata[15:0] = r_swap_count;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_mem_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (s1_byteenable[b]) begin
          r_mem[w_shadow_addr][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
      end
    end else if (r_cp_wr) begin
      r_mem[{~r_active_bank, r_cp_wr_idx}] <= r_cp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_active_bank    <= 1'b0;
      r_overrun        <= 1'b0;
      r_swap_count     <= '0;
      r_cp_idx         <= '0;
      r_cp_wr          <= 1'b0;
      r_cp_wr_idx      <= '0;
      r_cp_data        <= '0;
      s1_readdata      <= '0;
      s1_readdatavalid <= 1'b0;
      s2_readdata      <= '0;
      s2_readdatavalid <= 1'b0;
    end else begin
      s1_readdatavalid <= w_s1_rd;
      if (w_s1_rd) begin
        s1_readdata <= w_ctrl_space ? w_ctrl_rdata : r_mem[w_shadow_addr];
      end
      s2_readdatavalid <= s2_read;
      if (s2_read) begin
        s2_readdata <= r_mem[{r_active_bank, s2_address}];
      end

      r_cp_wr <= w_cp_rd;
      if (w_cp_rd) begin
        r_cp_data   <= r_mem[{r_active_bank, r_cp_idx[ADDR_W-1:0]}];
        r_cp_wr_idx <= r_cp_idx[ADDR_W-1:0];
        r_cp_idx    <= r_cp_idx + (ADDR_W+1)'(1);
      end

      // A new overrun wins over a simultaneous clear.
      if (w_commit & w_busy) begin
        r_overrun <= 1'b1;
      end else if (w_clr_ovr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_commit) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (frame_strobe) begin
            r_active_bank <= ~r_active_bank;
            r_swap_count  <= r_swap_count + 16'd1;
            r_cp_idx      <= '0;
            r_state       <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (w_cp_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_parameter_shadow_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_parameter_shadow_ram
// Brief    : Randomised self-checking bench against a two-bank array model.
// Revision : 1.0
// ============================================================================
module tb_parameter_shadow_ram;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W:0]   s1_address = '0;
  logic              s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic [3:0]        s1_byteenable = '0;
  logic [31:0]       s1_writedata = '0;
  logic [31:0]       s1_readdata;
  logic              s1_readdatavalid, s1_waitrequest;
  logic [ADDR_W-1:0] s2_address = '0;
  logic              s2_read = 1'b0;
  logic [31:0]       s2_readdata;
  logic              s2_readdatavalid;
  logic              frame_strobe = 1'b0;
  logic              active_bank, busy;

  int checks = 0;
  int failures = 0;

  // Reference: two whole banks, which one is visible, swap counter, sticky flag.
  logic [31:0] m_mem [2][DEPTH];
  logic        m_act = 1'b0;
  int          m_swaps = 0;
  logic        m_ovr = 1'b0;

  parameter_shadow_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_read(s2_read), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid),
    .frame_strobe(frame_strobe), .active_bank(active_bank), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic s1_rd(input logic [ADDR_W:0] a, output logic [31:0] d, output logic v);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = a;
    step();
    d = s1_readdata; v = s1_readdatavalid;
    s1_chipselect = 1'b0; s1_read = 1'b0;
  endtask

  task automatic s1_wr(input logic [ADDR_W:0] a, input logic [3:0] be, input logic [31:0] d);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = a; s1_byteenable = be; s1_writedata = d;
    step();
    s1_chipselect = 1'b0; s1_write = 1'b0;
  endtask

  task automatic s2_rd(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
    s2_read = 1'b1; s2_address = a;
    step();
    d = s2_readdata; v = s2_readdatavalid;
    s2_read = 1'b0;
  endtask

  task automatic pulse_strobe();
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
  endtask

  task automatic m_write(input int a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    m_mem[!m_act][a] = (m_mem[!m_act][a] & ~mask) | (d & mask);
  endtask

  task automatic m_swap();
    m_act = ~m_act;
    m_swaps = (m_swaps + 1) & 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) m_mem[!m_act][i] = m_mem[m_act][i];
  endtask

  // Runs the copy phase; s2 reads issued with probability given by mode (0 none, 1 alternate, 2 random).
  task automatic run_copy(input int mode, output int cyc);
    logic rd;
    logic [ADDR_W-1:0] a;
    cyc = 0;
    while (busy && cyc < 500) begin
      rd = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? 1'($urandom % 2) : 1'b0;
      a = ADDR_W'($urandom_range(0, DEPTH-1));
      s2_read = rd; s2_address = a;
      step();
      cyc++;
      if (rd) begin
        checks++;
        if (s2_readdatavalid !== 1'b1 || s2_readdata !== m_mem[m_act][a]) begin
          failures++;
          $display("FAIL copy_s2_read a=%0d: got v=%b d=%h, expected v=1 d=%h", a, s2_readdatavalid, s2_readdata, m_mem[m_act][a]);
        end
      end
    end
    s2_read = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL copy_timeout: busy=%b after %0d cycles, expected 0", busy, cyc); end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    reset = 1'b1; repeat (3) step(); reset = 1'b0;
    checks++; if ({busy, active_bank, s1_readdatavalid, s2_readdatavalid, s1_waitrequest} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs: got %b expected 00000", {busy, active_bank, s1_readdatavalid, s2_readdatavalid, s1_waitrequest}); end
    checks++; if (s1_readdata !== 32'h0 || s2_readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata: got %h/%h expected 0/0", s1_readdata, s2_readdata); end
    s1_rd(5'h10, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got v=%b d=%h expected v=1 d=0", v, d); end
    s1_rd(5'h11, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL reset_swaps: got v=%b d=%h expected v=1 d=0", v, d); end
    s2_read = 1'b1; s2_address = 4'd5; #1;
    checks++; if (s2_readdatavalid !== 1'b0) begin failures++; $display("FAIL s2_latency_early: got %b expected 0", s2_readdatavalid); end
    step(); s2_read = 1'b0;
    checks++; if (s2_readdatavalid !== 1'b1) begin failures++; $display("FAIL s2_latency: got %b expected 1", s2_readdatavalid); end
    step();
    checks++; if (s2_readdatavalid !== 1'b0) begin failures++; $display("FAIL s2_valid_pulse: got %b expected 0", s2_readdatavalid); end
  endtask

  task automatic test_fill_and_swap();
    logic [31:0] d, r; logic v; int cyc; int a;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom; s1_wr(5'(i), 4'hF, d); m_write(i, 4'hF, d);
    end
    repeat (4) begin
      a = $urandom_range(0, DEPTH-1); s1_rd(5'(a), r, v);
      checks++; if (v !== 1'b1 || r !== m_mem[!m_act][a]) begin
        failures++; $display("FAIL shadow_readback a=%0d: got %h expected %h", a, r, m_mem[!m_act][a]); end
    end
    s1_wr(5'h10, 4'hF, 32'h1);
    s1_rd(5'h10, r, v);
    checks++; if (r !== {29'b0, m_ovr, 1'b1, m_act}) begin failures++; $display("FAIL ctrl_armed: got %h expected %h", r, {29'b0, m_ovr, 1'b1, m_act}); end
    pulse_strobe(); m_swap();
    run_copy(0, cyc);
    checks++; if (cyc != DEPTH + 1) begin failures++; $display("FAIL copy_min_len: got %0d expected %0d", cyc, DEPTH + 1); end
    checks++; if (active_bank !== m_act) begin failures++; $display("FAIL swap_bank: got %b expected %b", active_bank, m_act); end
    for (int i = 0; i < DEPTH; i++) begin
      s2_rd(4'(i), r, v);
      checks++; if (v !== 1'b1 || r !== m_mem[m_act][i]) begin failures++; $display("FAIL active_word %0d: got %h expected %h", i, r, m_mem[m_act][i]); end
      s1_rd(5'(i), r, v);
      checks++; if (v !== 1'b1 || r !== m_mem[!m_act][i]) begin failures++; $display("FAIL copied_word %0d: got %h expected %h", i, r, m_mem[!m_act][i]); end
    end
  endtask

  task automatic test_byteenable();
    logic [31:0] r; logic v;
    s1_wr(5'd5, 4'hF, 32'h11223344); m_write(5, 4'hF, 32'h11223344);
    s1_wr(5'd5, 4'b0011, 32'hA5A5A5A5); m_write(5, 4'b0011, 32'hA5A5A5A5);
    s1_rd(5'd5, r, v);
    checks++; if (v !== 1'b1 || r !== 32'h1122A5A5) begin failures++; $display("FAIL byteenable: got %h expected 1122a5a5", r); end
    s2_rd(4'd5, r, v);
    checks++; if (r !== m_mem[m_act][5]) begin failures++; $display("FAIL s2_old_bank: got %h expected %h", r, m_mem[m_act][5]); end
  endtask

  task automatic test_commit_hold();
    logic [31:0] r; logic v; int cyc; int bad;
    s1_wr(5'h10, 4'hF, 32'h1);
    bad = 0;
    repeat (20) begin step(); if (busy !== 1'b1 || active_bank !== m_act) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL armed_hold: got %0d bad cycles expected 0", bad); end
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 5'd5; s1_byteenable = 4'hF; s1_writedata = 32'hDEADBEEF; #1;
    checks++; if (s1_waitrequest !== 1'b1) begin failures++; $display("FAIL waitrequest_armed: got %b expected 1", s1_waitrequest); end
    step(); step();
    s1_chipselect = 1'b0; s1_write = 1'b0;
    s1_rd(5'h10, r, v);
    checks++; if (v !== 1'b1 || r !== {29'b0, m_ovr, 1'b1, m_act}) begin failures++; $display("FAIL ctrl_no_stall: got v=%b d=%h expected v=1 d=%h", v, r, {29'b0, m_ovr, 1'b1, m_act}); end
    pulse_strobe(); m_swap();
    checks++; if (active_bank !== m_act) begin failures++; $display("FAIL swap_toggle: got %b expected %b", active_bank, m_act); end
    run_copy(1, cyc);
    checks++; if (cyc < 2 * DEPTH + 1) begin failures++; $display("FAIL copy_paused_len: got %0d expected >= %0d", cyc, 2 * DEPTH + 1); end
    s2_rd(4'd5, r, v);
    checks++; if (r !== 32'h1122A5A5) begin failures++; $display("FAIL s2_new_bank: got %h expected 1122a5a5", r); end
    for (int i = 0; i < DEPTH; i++) begin
      s1_rd(5'(i), r, v);
      checks++; if (r !== m_mem[m_act][i]) begin failures++; $display("FAIL shadow_eq_active %0d: got %h expected %h", i, r, m_mem[m_act][i]); end
    end
    s1_rd(5'h11, r, v);
    checks++; if (r !== 32'(m_swaps)) begin failures++; $display("FAIL swaps_count: got %0d expected %0d", r, m_swaps); end
  endtask

  task automatic test_overrun();
    logic [31:0] r; logic v; int cyc;
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 5'h10; s1_byteenable = 4'hF; s1_writedata = 32'h1;
    frame_strobe = 1'b1; step();
    s1_chipselect = 1'b0; s1_write = 1'b0; frame_strobe = 1'b0;
    checks++; if (busy !== 1'b1 || active_bank !== m_act) begin failures++; $display("FAIL same_cycle_strobe: got busy=%b bank=%b expected 1/%b", busy, active_bank, m_act); end
    repeat (3) step();
    pulse_strobe(); m_swap();
    step(); step();
    s1_wr(5'h10, 4'hF, 32'h1); m_ovr = 1'b1;
    run_copy(0, cyc);
    s1_rd(5'h10, r, v);
    checks++; if (r !== {29'b0, m_ovr, 1'b0, m_act}) begin failures++; $display("FAIL overrun_set: got %h expected %h", r, {29'b0, m_ovr, 1'b0, m_act}); end
    s1_rd(5'h11, r, v);
    checks++; if (r !== 32'(m_swaps)) begin failures++; $display("FAIL no_extra_swap: got %0d expected %0d", r, m_swaps); end
    s1_wr(5'h10, 4'hF, 32'h2); m_ovr = 1'b0;
    s1_rd(5'h10, r, v);
    checks++; if (r !== {29'b0, m_ovr, 1'b0, m_act}) begin failures++; $display("FAIL overrun_clear: got %h expected %h", r, {29'b0, m_ovr, 1'b0, m_act}); end
    s1_wr(5'h10, 4'hF, 32'h1);
    pulse_strobe(); m_swap();
    s1_wr(5'h10, 4'hF, 32'h3); m_ovr = 1'b1;
    run_copy(0, cyc);
    s1_rd(5'h10, r, v);
    checks++; if (r !== {29'b0, m_ovr, 1'b0, m_act}) begin failures++; $display("FAIL overrun_set_wins: got %h expected %h", r, {29'b0, m_ovr, 1'b0, m_act}); end
    s1_wr(5'h10, 4'hF, 32'h2); m_ovr = 1'b0;
    s1_rd(5'h12, r, v);
    checks++; if (v !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL ctrl_other_offset: got %h expected 0", r); end
  endtask

  task automatic test_random();
    logic [31:0] d, r; logic v; logic [3:0] be; int a; int cyc;
    for (int round = 0; round < 6; round++) begin
      repeat ($urandom_range(3, 10)) begin
        a = $urandom_range(0, DEPTH-1); be = 4'($urandom); d = $urandom;
        s1_wr(5'(a), be, d); m_write(a, be, d);
      end
      repeat (3) begin
        a = $urandom_range(0, DEPTH-1); s1_rd(5'(a), r, v);
        checks++; if (v !== 1'b1 || r !== m_mem[!m_act][a]) begin failures++; $display("FAIL rand_shadow a=%0d: got %h expected %h", a, r, m_mem[!m_act][a]); end
        a = $urandom_range(0, DEPTH-1); s2_rd(4'(a), r, v);
        checks++; if (v !== 1'b1 || r !== m_mem[m_act][a]) begin failures++; $display("FAIL rand_active a=%0d: got %h expected %h", a, r, m_mem[m_act][a]); end
      end
      s1_wr(5'h10, 4'hF, 32'h1);
      repeat ($urandom_range(0, 5)) step();
      pulse_strobe(); m_swap();
      run_copy(2, cyc);
    end
    s1_rd(5'h11, r, v);
    checks++; if (r !== 32'(m_swaps)) begin failures++; $display("FAIL rand_swaps: got %0d expected %0d", r, m_swaps); end
  endtask

  task automatic test_reset_mid_copy();
    logic [31:0] r; logic v;
    s1_wr(5'h10, 4'hF, 32'h1);
    pulse_strobe();
    repeat (7) step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (busy !== 1'b0 || active_bank !== 1'b0) begin failures++; $display("FAIL reset_abort: got busy=%b bank=%b expected 0/0", busy, active_bank); end
    s1_rd(5'h11, r, v);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_abort_swaps: got %h expected 0", r); end
    s1_rd(5'h10, r, v);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_abort_ctrl: got %h expected 0", r); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_and_swap();
    test_byteenable();
    test_commit_hold();
    test_overrun();
    test_random();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
